// File: rtl/vadd_sequencer_pkg.sv
// Shared widths, FSM state type and FP16 helpers for the vector add/subtract sequencer.
// Imported by the interface, the control FSM and the top-level datapath.
package vadd_sequencer_pkg;

    localparam int FP16_W   = 16;
    localparam int SIGN_BIT = 15;
    localparam int VLEN     = 16;
    localparam int IDX_W    = 4;
    localparam int NREG     = 8;
    localparam int REG_W    = 3;
    localparam int ADDR_W   = REG_W + IDX_W;
    localparam int CNT_W    = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    function automatic logic [FP16_W-1:0] fp16_neg(input logic [FP16_W-1:0] x);
        return {~x[SIGN_BIT], x[SIGN_BIT-1:0]};
    endfunction

    // Requests longer than a register hold are trimmed to a full vector.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] l);
        return (l > CNT_W'(VLEN)) ? CNT_W'(VLEN) : l;
    endfunction

endpackage

// File: rtl/vadd_sequencer_if.sv
// Bundle of the issue-side, register-file and adder signals around the sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface vadd_sequencer_if;
    import vadd_sequencer_pkg::*;

    logic              start;
    logic              op_sub;
    logic [REG_W-1:0]  src_a;
    logic [REG_W-1:0]  src_b;
    logic [REG_W-1:0]  dst;
    logic [CNT_W-1:0]  len;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [FP16_W-1:0] rd_data_a;
    logic [FP16_W-1:0] rd_data_b;
    logic [FP16_W-1:0] add_a;
    logic [FP16_W-1:0] add_b;
    logic [FP16_W-1:0] add_sum;
    logic              add_ovf;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [FP16_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              ovf_sticky;
    logic [IDX_W-1:0]  ovf_idx;

    modport slave (
        input  start, op_sub, src_a, src_b, dst, len,
        input  rd_data_a, rd_data_b, add_sum, add_ovf,
        output rd_en, rd_addr_a, rd_addr_b, add_a, add_b,
        output wr_en, wr_addr, wr_data, busy, done, ovf_sticky, ovf_idx
    );

    modport master (
        output start, op_sub, src_a, src_b, dst, len,
        output rd_data_a, rd_data_b, add_sum, add_ovf,
        input  rd_en, rd_addr_a, rd_addr_b, add_a, add_b,
        input  wr_en, wr_addr, wr_data, busy, done, ovf_sticky, ovf_idx
    );

endinterface

// File: rtl/vadd_seq_ctrl.sv
// Sequencer FSM: accepts a request, issues one element read per cycle, drains the
// two-stage pipe and pulses done. Operation fields are latched at acceptance.
module vadd_seq_ctrl
    import vadd_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [REG_W-1:0] src_a,
    input  logic [REG_W-1:0] src_b,
    input  logic [REG_W-1:0] dst,
    input  logic [CNT_W-1:0] len,
    output logic             accept,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_idx,
    output logic [REG_W-1:0] src_a_r,
    output logic [REG_W-1:0] src_b_r,
    output logic [REG_W-1:0] dst_r,
    output logic             op_sub_r,
    output logic             busy,
    output logic             done
);

    seq_state_e       state_r;
    logic [CNT_W-1:0] issue_k_r;
    logic [CNT_W-1:0] len_r;
    logic             drain_r;
    logic             rd_en_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] len_s;

    assign len_s  = clamp_len(len);
    assign accept = (state_r == IDLE) && start;
    assign rd_en  = rd_en_r;
    assign rd_idx = issue_k_r[IDX_W-1:0];
    assign busy   = busy_r;
    assign done   = done_r;

    // State, issue counter and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            issue_k_r <= {CNT_W{1'b0}};
            len_r     <= {CNT_W{1'b0}};
            drain_r   <= 1'b0;
            rd_en_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            src_a_r   <= {REG_W{1'b0}};
            src_b_r   <= {REG_W{1'b0}};
            dst_r     <= {REG_W{1'b0}};
            op_sub_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r  <= 1'b0;
                    rd_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                    if (start) begin
                        src_a_r   <= src_a;
                        src_b_r   <= src_b;
                        dst_r     <= dst;
                        op_sub_r  <= op_sub;
                        len_r     <= len_s;
                        issue_k_r <= {CNT_W{1'b0}};
                        if (len_s == {CNT_W{1'b0}}) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= RUN;
                            rd_en_r <= 1'b1;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (issue_k_r + CNT_W'(1) == len_r) begin
                        rd_en_r <= 1'b0;
                        drain_r <= 1'b0;
                        state_r <= DRAIN;
                    end else begin
                        issue_k_r <= issue_k_r + CNT_W'(1);
                        rd_en_r   <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_r) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        drain_r <= 1'b1;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    rd_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/vadd_sequencer.sv
// Element-wise FP16 vector add/subtract sequencer: read stage, shared-adder stage
// and registered write-back, plus sticky first-overflow tracking.
module vadd_sequencer
    import vadd_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    vadd_sequencer_if.slave bus
);

    logic              accept_s;
    logic              rd_en_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [REG_W-1:0]  src_a_r;
    logic [REG_W-1:0]  src_b_r;
    logic [REG_W-1:0]  dst_r;
    logic              op_sub_r;
    logic              busy_s;
    logic              done_s;

    logic              a_vld_r;
    logic [IDX_W-1:0]  a_idx_r;
    logic [FP16_W-1:0] add_a_s;
    logic [FP16_W-1:0] add_b_s;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [FP16_W-1:0] wr_data_r;
    logic              ovf_sticky_r;
    logic [IDX_W-1:0]  ovf_idx_r;

    vadd_seq_ctrl u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start    (bus.start),
        .op_sub   (bus.op_sub),
        .src_a    (bus.src_a),
        .src_b    (bus.src_b),
        .dst      (bus.dst),
        .len      (bus.len),
        .accept   (accept_s),
        .rd_en    (rd_en_s),
        .rd_idx   (rd_idx_s),
        .src_a_r  (src_a_r),
        .src_b_r  (src_b_r),
        .dst_r    (dst_r),
        .op_sub_r (op_sub_r),
        .busy     (busy_s),
        .done     (done_s)
    );

    // Adder operands come straight from read data and are zero outside the adder stage.
    always_comb begin
        add_a_s = {FP16_W{1'b0}};
        add_b_s = {FP16_W{1'b0}};
        if (a_vld_r) begin
            add_a_s = bus.rd_data_a;
            if (op_sub_r) begin
                add_b_s = fp16_neg(bus.rd_data_b);
            end else begin
                add_b_s = bus.rd_data_b;
            end
        end else begin
            add_a_s = {FP16_W{1'b0}};
            add_b_s = {FP16_W{1'b0}};
        end
    end

    // Adder-stage tracking and result write-back register.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_r   <= 1'b0;
            a_idx_r   <= {IDX_W{1'b0}};
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= {FP16_W{1'b0}};
        end else begin
            a_vld_r <= rd_en_s;
            a_idx_r <= rd_idx_s;
            wr_en_r <= a_vld_r;
            if (a_vld_r) begin
                wr_addr_r <= {dst_r, a_idx_r};
                wr_data_r <= bus.add_sum;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
        end
    end

    // Overflow flag is cleared by a new request; only the first overflow sets the index.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky_r <= 1'b0;
            ovf_idx_r    <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            ovf_sticky_r <= 1'b0;
            ovf_idx_r    <= {IDX_W{1'b0}};
        end else if (a_vld_r && bus.add_ovf) begin
            ovf_sticky_r <= 1'b1;
            if (!ovf_sticky_r) begin
                ovf_idx_r <= a_idx_r;
            end else begin
                ovf_idx_r <= ovf_idx_r;
            end
        end else begin
            ovf_sticky_r <= ovf_sticky_r;
            ovf_idx_r    <= ovf_idx_r;
        end
    end

    assign bus.rd_en      = rd_en_s;
    assign bus.rd_addr_a  = {src_a_r, rd_idx_s};
    assign bus.rd_addr_b  = {src_b_r, rd_idx_s};
    assign bus.add_a      = add_a_s;
    assign bus.add_b      = add_b_s;
    assign bus.wr_en      = wr_en_r;
    assign bus.wr_addr    = wr_addr_r;
    assign bus.wr_data    = wr_data_r;
    assign bus.busy       = busy_s;
    assign bus.done       = done_s;
    assign bus.ovf_sticky = ovf_sticky_r;
    assign bus.ovf_idx    = ovf_idx_r;

endmodule

// File: tb/tb_vadd_sequencer.sv
// Scoreboard bench for vadd_sequencer with a register-file model and a stand-in FP16 adder.
// Cycle numbering: cycle 0 is the cycle in which start is sampled in IDLE.
module tb_vadd_sequencer;
    import vadd_sequencer_pkg::*;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vadd_sequencer_if bus ();
    vadd_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    logic [15:0] mem [0:NREG*VLEN-1];
    wr_t         exp_q [$];
    logic [15:0] addb_log [$];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    // Register file with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data_a <= mem[bus.rd_addr_a];
            bus.rd_data_b <= mem[bus.rd_addr_b];
        end
    end

    function automatic logic [16:0] adder_model(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h3C00 && b == 16'h3C00) return {1'b0, 16'h4000};
        else if (a == 16'h3C00 && b == 16'hBC00) return {1'b0, 16'h0000};
        else if (a == 16'h7800 && b == 16'h7800) return {1'b1, 16'h7C00};
        else return {1'b0, a + b};
    endfunction

    always_comb begin
        {bus.add_ovf, bus.add_sum} = adder_model(bus.add_a, bus.add_b);
    end

    task automatic fill(input logic [2:0] r, input logic [15:0] base, input logic [15:0] step);
        for (int k = 0; k < VLEN; k++) mem[{r, 4'(k)}] = base + 16'(k) * step;
    endtask

    task automatic issue(input bit sub, input logic [2:0] sa, input logic [2:0] sb,
                         input logic [2:0] d, input logic [4:0] l);
        bus.start = 1'b1; bus.op_sub = sub; bus.src_a = sa; bus.src_b = sb; bus.dst = d; bus.len = l;
    endtask

    // Runs one operation from the accepting edge, scoring every write against exp_q.
    task automatic run_op(input int budget, input int rst_cycle, input bit hold,
                          input logic [2:0] sa, input logic [2:0] sb,
                          output int done_cyc, output int nwr, output int first_wr,
                          output int last_wr, output int nrd, output bit busy_drop,
                          output int post_rst_bad);
        int  k_rd;
        bit  seen_busy;
        wr_t e;
        done_cyc = -1; nwr = 0; first_wr = -1; last_wr = -1; nrd = 0;
        busy_drop = 1'b0; post_rst_bad = 0; k_rd = 0; seen_busy = 1'b0;
        addb_log.delete();
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) begin
                bus.start = 1'b0;
                bus.src_a = ~bus.src_a; bus.src_b = ~bus.src_b; bus.dst = ~bus.dst;
                bus.op_sub = ~bus.op_sub; bus.len = 5'd1;
            end
            if (bus.rd_en) begin
                total_cnt++;
                if (bus.rd_addr_a !== {sa, k_rd[3:0]} || bus.rd_addr_b !== {sb, k_rd[3:0]})
                    $display("FAIL rd_addr: got %h/%h expected %h/%h", bus.rd_addr_a, bus.rd_addr_b,
                             {sa, k_rd[3:0]}, {sb, k_rd[3:0]});
                else pass_cnt++;
                k_rd++; nrd++;
            end
            if (c >= 2 && (c - 2) < nrd) addb_log.push_back(bus.add_b);
            if (bus.wr_en) begin
                nwr++;
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_write: got addr %h data %h expected no write", bus.wr_addr, bus.wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.wr_addr !== e.addr || bus.wr_data !== e.data)
                        $display("FAIL write: got addr %h data %h expected addr %h data %h",
                                 bus.wr_addr, bus.wr_data, e.addr, e.data);
                    else pass_cnt++;
                end
            end
            if (rst_cycle == 0 || c <= rst_cycle) begin
                if (bus.busy) seen_busy = 1'b1;
                else if (seen_busy && done_cyc < 0 && !bus.done) busy_drop = 1'b1;
            end
            if (rst_cycle > 0 && c > rst_cycle && (bus.wr_en || bus.busy || bus.done)) post_rst_bad++;
            if (bus.done && done_cyc < 0) done_cyc = c;
            if (c == rst_cycle) rst = 1'b1;
            if (rst_cycle > 0 && c == rst_cycle + 1) rst = 1'b0;
            if (done_cyc > 0 && rst_cycle == 0) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.op_sub = 1'b0; bus.src_a = 3'd0; bus.src_b = 3'd0; bus.dst = 3'd0; bus.len = 5'd0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({bus.rd_en, bus.wr_en, bus.busy, bus.done, bus.ovf_sticky} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected 00000", {bus.rd_en, bus.wr_en, bus.busy, bus.done, bus.ovf_sticky});
        else pass_cnt++;
        total_cnt++;
        if ({bus.rd_addr_a, bus.rd_addr_b, bus.wr_addr, bus.wr_data, bus.add_a, bus.add_b, bus.ovf_idx} !== 73'd0)
            $display("FAIL reset_data: got %h expected 0",
                     {bus.rd_addr_a, bus.rd_addr_b, bus.wr_addr, bus.wr_data, bus.add_a, bus.add_b, bus.ovf_idx});
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add(input bit sub);
        int dc, nw, fw, lw, nr, pr; bit bd;
        fill(3'd1, 16'h3C00, 16'h0000);
        fill(3'd2, 16'h3C00, 16'h0000);
        for (int k = 0; k < 4; k++) exp_q.push_back('{addr: {3'd5, 4'(k)}, data: sub ? 16'h0000 : 16'h4000});
        @(negedge clk);
        issue(sub, 3'd1, 3'd2, 3'd5, 5'd4);
        run_op(30, 0, 1'b0, 3'd1, 3'd2, dc, nw, fw, lw, nr, bd, pr);
        total_cnt++;
        if (dc !== 7 || nw !== 4 || fw !== 3 || lw !== 6 || nr !== 4)
            $display("FAIL add_timing(sub=%0d): got done %0d writes %0d first %0d last %0d reads %0d expected 7 4 3 6 4",
                     sub, dc, nw, fw, lw, nr);
        else pass_cnt++;
        total_cnt++;
        if (bd !== 1'b0 || bus.ovf_sticky !== 1'b0 || exp_q.size() !== 0)
            $display("FAIL add_status(sub=%0d): got busy_drop %0d ovf %0d leftover %0d expected 0 0 0",
                     sub, bd, bus.ovf_sticky, exp_q.size());
        else pass_cnt++;
        if (sub) begin
            total_cnt++;
            if (addb_log.size() !== 4) $display("FAIL sub_addb_count: got %0d expected 4", addb_log.size());
            else pass_cnt++;
            foreach (addb_log[i]) begin
                total_cnt++;
                if (addb_log[i] !== 16'hBC00) $display("FAIL sub_addb[%0d]: got %h expected bc00", i, addb_log[i]);
                else pass_cnt++;
            end
        end
        exp_q.delete();
    endtask

    task automatic test_overflow();
        int dc, nw, fw, lw, nr, pr; bit bd;
        fill(3'd3, 16'h3C00, 16'h0000);
        fill(3'd4, 16'h3C00, 16'h0000);
        mem[{3'd3, 4'd5}] = 16'h7800; mem[{3'd4, 4'd5}] = 16'h7800;
        mem[{3'd3, 4'd9}] = 16'h7800; mem[{3'd4, 4'd9}] = 16'h7800;
        for (int k = 0; k < 16; k++)
            exp_q.push_back('{addr: {3'd6, 4'(k)}, data: (k == 5 || k == 9) ? 16'h7C00 : 16'h4000});
        @(negedge clk);
        issue(1'b0, 3'd3, 3'd4, 3'd6, 5'd16);
        run_op(40, 0, 1'b0, 3'd3, 3'd4, dc, nw, fw, lw, nr, bd, pr);
        total_cnt++;
        if (dc !== 19 || nw !== 16 || lw !== 18)
            $display("FAIL ovf_timing: got done %0d writes %0d last %0d expected 19 16 18", dc, nw, lw);
        else pass_cnt++;
        total_cnt++;
        if (bus.ovf_sticky !== 1'b1 || bus.ovf_idx !== 4'd5)
            $display("FAIL ovf_flag: got sticky %0d idx %0d expected 1 5", bus.ovf_sticky, bus.ovf_idx);
        else pass_cnt++;
        exp_q.delete();
    endtask

    task automatic test_len_zero_and_clamp();
        int dc, nw, fw, lw, nr, pr; bit bd;
        @(negedge clk);
        issue(1'b0, 3'd1, 3'd2, 3'd5, 5'd0);
        run_op(10, 0, 1'b0, 3'd1, 3'd2, dc, nw, fw, lw, nr, bd, pr);
        total_cnt++;
        if (dc !== 1 || nr !== 0 || nw !== 0 || bus.busy !== 1'b0)
            $display("FAIL len_zero: got done %0d reads %0d writes %0d busy %0d expected 1 0 0 0", dc, nr, nw, bus.busy);
        else pass_cnt++;
        total_cnt++;
        if (bus.ovf_sticky !== 1'b0 || bus.ovf_idx !== 4'd0)
            $display("FAIL ovf_clear: got sticky %0d idx %0d expected 0 0", bus.ovf_sticky, bus.ovf_idx);
        else pass_cnt++;
        for (int k = 0; k < 16; k++) exp_q.push_back('{addr: {3'd7, 4'(k)}, data: 16'h4000});
        @(negedge clk);
        issue(1'b0, 3'd1, 3'd2, 3'd7, 5'd20);
        run_op(40, 0, 1'b0, 3'd1, 3'd2, dc, nw, fw, lw, nr, bd, pr);
        total_cnt++;
        if (dc !== 19 || nw !== 16 || nr !== 16 || exp_q.size() !== 0)
            $display("FAIL clamp: got done %0d writes %0d reads %0d leftover %0d expected 19 16 16 0",
                     dc, nw, nr, exp_q.size());
        else pass_cnt++;
        exp_q.delete();
    endtask

    task automatic test_varied();
        int dc, nw, fw, lw, nr, pr; bit bd;
        logic [15:0] a, b;
        fill(3'd0, 16'h0100, 16'h0011);
        fill(3'd7, 16'h8001, 16'h0020);
        for (int k = 0; k < 5; k++) begin
            a = mem[{3'd0, 4'(k)}]; b = mem[{3'd7, 4'(k)}];
            exp_q.push_back('{addr: {3'd3, 4'(k)}, data: a + {~b[15], b[14:0]}});
        end
        @(negedge clk);
        issue(1'b1, 3'd0, 3'd7, 3'd3, 5'd5);
        run_op(30, 0, 1'b0, 3'd0, 3'd7, dc, nw, fw, lw, nr, bd, pr);
        total_cnt++;
        if (dc !== 8 || nw !== 5 || exp_q.size() !== 0)
            $display("FAIL varied: got done %0d writes %0d leftover %0d expected 8 5 0", dc, nw, exp_q.size());
        else pass_cnt++;
        foreach (addb_log[i]) begin
            b = mem[{3'd7, 4'(i)}];
            total_cnt++;
            if (addb_log[i] !== {~b[15], b[14:0]})
                $display("FAIL varied_addb[%0d]: got %h expected %h", i, addb_log[i], {~b[15], b[14:0]});
            else pass_cnt++;
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int dc, nw, fw, lw, nr, pr; bit bd;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 3; k++) exp_q.push_back('{addr: {3'd2, 4'(k)}, data: 16'h4000});
        @(negedge clk);
        issue(1'b0, 3'd1, 3'd2, 3'd2, 5'd3);
        run_op(20, 0, 1'b1, 3'd1, 3'd2, dc, nw, fw, lw, nr, bd, pr);
        total_cnt++;
        if (dc !== 6 || nw !== 3 || bd !== 1'b0)
            $display("FAIL b2b_first: got done %0d writes %0d busy_drop %0d expected 6 3 0", dc, nw, bd);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_en !== 1'b0)
            $display("FAIL b2b_idle: got busy %0d done %0d rd_en %0d expected 0 0 0", bus.busy, bus.done, bus.rd_en);
        else pass_cnt++;
        run_op(20, 0, 1'b0, 3'd1, 3'd2, dc, nw, fw, lw, nr, bd, pr);
        total_cnt++;
        if (dc !== 6 || nw !== 3 || bd !== 1'b0 || exp_q.size() !== 0)
            $display("FAIL b2b_second: got done %0d writes %0d busy_drop %0d leftover %0d expected 6 3 0 0",
                     dc, nw, bd, exp_q.size());
        else pass_cnt++;
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int dc, nw, fw, lw, nr, pr; bit bd;
        for (int k = 0; k < 2; k++) exp_q.push_back('{addr: {3'd4, 4'(k)}, data: 16'h4000});
        @(negedge clk);
        issue(1'b0, 3'd1, 3'd2, 3'd4, 5'd8);
        run_op(14, 4, 1'b0, 3'd1, 3'd2, dc, nw, fw, lw, nr, bd, pr);
        total_cnt++;
        if (dc !== -1 || pr !== 0 || nw !== 2 || exp_q.size() !== 0)
            $display("FAIL rst_mid: got done %0d post_rst_active %0d writes %0d leftover %0d expected -1 0 2 0",
                     dc, pr, nw, exp_q.size());
        else pass_cnt++;
        exp_q.delete();
        for (int k = 0; k < 2; k++) exp_q.push_back('{addr: {3'd6, 4'(k)}, data: 16'h4000});
        @(negedge clk);
        issue(1'b0, 3'd1, 3'd2, 3'd6, 5'd2);
        run_op(20, 0, 1'b0, 3'd1, 3'd2, dc, nw, fw, lw, nr, bd, pr);
        total_cnt++;
        if (dc !== 5 || nw !== 2 || exp_q.size() !== 0)
            $display("FAIL rst_restart: got done %0d writes %0d leftover %0d expected 5 2 0", dc, nw, exp_q.size());
        else pass_cnt++;
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_add(1'b0);
        test_add(1'b1);
        test_overflow();
        test_len_zero_and_clamp();
        test_varied();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
